// File: rtl/seven_seg_scan_decoder.sv
// Seven-segment scan decoder. It watches a multiplexed, active-low 8-digit
// display bus and rebuilds the displayed BCD digits from it. A digit is
// captured once its anode/segment pair has been stable for SETTLE_CYCLES
// cycles. The block also reports completed frames, undecodable segment
// patterns, multi-anode selects and scan stalls.
module seven_seg_scan_decoder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  anode_activate,
    input  logic [6:0]  led_out,
    output logic [31:0] digit_values,
    output logic [7:0]  digit_valid,
    output logic [7:0]  digit_blank,
    output logic        frame_done,
    output logic        seg_error,
    output logic        anode_error,
    output logic        scan_stalled
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam int unsigned TO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    logic [7:0]      a_sync [SYNC_STAGES];
    logic [6:0]      l_sync [SYNC_STAGES];
    logic [7:0]      sa;
    logic [6:0]      sl;
    logic [7:0]      prev_sa;
    logic [6:0]      prev_sl;
    logic            sa_changed;
    logic            changed;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [7:0]      cnt;
    logic [7:0]      cnt_next;
    logic            capture;

    logic [TO_W-1:0] to_cnt;
    logic [7:0]      seen;
    logic [7:0]      seen_with;
    logic [2:0]      digit_idx;
    logic            one_low;
    logic            dec_legal;
    logic            dec_blank;
    logic [3:0]      dec_value;

    // Active-low segment pattern to {legal, blank, nibble}.
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'b0000001: r = {2'b10, 4'h0};
            7'b1001111: r = {2'b10, 4'h1};
            7'b0010010: r = {2'b10, 4'h2};
            7'b0000110: r = {2'b10, 4'h3};
            7'b1001100: r = {2'b10, 4'h4};
            7'b0100100: r = {2'b10, 4'h5};
            7'b0100000: r = {2'b10, 4'h6};
            7'b0001111: r = {2'b10, 4'h7};
            7'b0000000: r = {2'b10, 4'h8};
            7'b0000100: r = {2'b10, 4'h9};
            7'b1111111: r = {2'b11, 4'hF};
            default:    r = {2'b00, 4'h0};
        endcase
        return r;
    endfunction

    // Input synchronisers; reset to the idle (all-high) bus value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                a_sync[i] <= '1;
                l_sync[i] <= '1;
            end
        end else begin
            a_sync[0] <= anode_activate;
            l_sync[0] <= led_out;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                a_sync[i] <= a_sync[i-1];
                l_sync[i] <= l_sync[i-1];
            end
        end
    end

    assign sa = a_sync[SYNC_STAGES-1];
    assign sl = l_sync[SYNC_STAGES-1];

    // Previous-cycle copies of the synchronised buses for change detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_sa <= '1;
            prev_sl <= '1;
        end else begin
            prev_sa <= sa;
            prev_sl <= sl;
        end
    end

    assign sa_changed = (sa != prev_sa);
    assign changed    = sa_changed || (sl != prev_sl);

    // Settle FSM: decides when the current anode/segment pair is captured.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sa != 8'hFF) begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                end
            end
            ST_SETTLE: begin
                if (changed) begin
                    cnt_next = '0;
                    if (sa == 8'hFF) state_next = ST_IDLE;
                end else if (cnt == SETTLE_LAST) begin
                    capture    = 1'b1;
                    state_next = ST_HELD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ST_HELD: begin
                if (changed) begin
                    cnt_next   = '0;
                    state_next = (sa == 8'hFF) ? ST_IDLE : ST_SETTLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Settle FSM state and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Digit index, decode result and frame-mask preview for the capture path.
    always_comb begin
        digit_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!sa[i]) digit_idx = 3'(i);
        end
        one_low = $onehot(~sa);
        {dec_legal, dec_blank, dec_value} = decode(sl);
        seen_with = seen | ~sa;
    end

    // Capture action: digit state, frame tracking and error pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit_values <= '0;
            digit_valid  <= '0;
            digit_blank  <= '0;
            frame_done   <= 1'b0;
            seg_error    <= 1'b0;
            anode_error  <= 1'b0;
            seen         <= '0;
        end else begin
            frame_done  <= 1'b0;
            seg_error   <= 1'b0;
            anode_error <= 1'b0;
            if (capture) begin
                if (one_low) begin
                    if (dec_legal) begin
                        digit_values[{digit_idx, 2'b00} +: 4] <= dec_value;
                        digit_valid[digit_idx] <= 1'b1;
                        digit_blank[digit_idx] <= dec_blank;
                    end else begin
                        digit_valid[digit_idx] <= 1'b0;
                        digit_blank[digit_idx] <= 1'b0;
                        seg_error              <= 1'b1;
                    end
                    if (seen_with == 8'hFF) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                    end else begin
                        seen <= seen_with;
                    end
                end else begin
                    anode_error <= 1'b1;
                end
            end
        end
    end

    // Stall timer: cycles since the last anode change, saturating.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (sa_changed) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign scan_stalled = (to_cnt == TO_MAX);

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed scenarios plus random scan
// traffic, checked each cycle against a history-based reference model.
module tb_seven_seg_scan_decoder;

    localparam int S  = 2;
    localparam int ST = 4;
    localparam int TO = 50;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  anode_activate = 8'hFF;
    logic [6:0]  led_out = 7'h7F;
    logic [31:0] digit_values;
    logic [7:0]  digit_valid;
    logic [7:0]  digit_blank;
    logic        frame_done;
    logic        seg_error;
    logic        anode_error;
    logic        scan_stalled;

    seven_seg_scan_decoder #(
        .SYNC_STAGES    (S),
        .SETTLE_CYCLES  (ST),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .anode_activate (anode_activate),
        .led_out        (led_out),
        .digit_values   (digit_values),
        .digit_valid    (digit_valid),
        .digit_blank    (digit_blank),
        .frame_done     (frame_done),
        .seg_error      (seg_error),
        .anode_error    (anode_error),
        .scan_stalled   (scan_stalled)
    );

    always #5 clock = ~clock;

    // Segment patterns for digits 0..9 (active low, a..g in bits 6..0).
    logic [6:0] PAT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100};

    int checks = 0;
    int errors = 0;

    // Reference model: pin history since reset plus the decoded digit image.
    logic [7:0] ha [$];
    logic [6:0] hl [$];
    logic [3:0] m_values [8];
    bit         m_valid [8];
    bit         m_blank [8];
    bit         m_seen [8];
    bit         m_fd, m_se, m_ae;
    int         m_n;

    // DUT event bookkeeping (observed values, compared to literals).
    int fd_cnt = 0, se_cnt = 0, ae_cnt = 0;
    int last_fd_step = -1, stall_rise = -1, stall_fall = -1;
    bit prev_stall = 1'b0;

    // Synchronised bus pair seen by the decoder at step idx.
    function automatic logic [14:0] pair_at(input int idx);
        int j;
        j = idx - S;
        if (j < 0) return 15'h7FFF;
        return {ha[j], hl[j]};
    endfunction

    function automatic int lookup(input logic [6:0] p);
        for (int v = 0; v < 10; v++) if (PAT[v] == p) return v;
        if (p == 7'h7F) return 15;
        return -1;
    endfunction

    task automatic model_clear();
        ha.delete();
        hl.delete();
        for (int d = 0; d < 8; d++) begin
            m_values[d] = 4'h0;
            m_valid[d]  = 1'b0;
            m_blank[d]  = 1'b0;
            m_seen[d]   = 1'b0;
        end
        m_n = 0;
    endtask

    task automatic model_step(input logic [7:0] a, input logic [6:0] l, input logic r);
        int e, v, d, all;
        logic [14:0] cur;
        bit stable;
        m_fd = 1'b0;
        m_se = 1'b0;
        m_ae = 1'b0;
        if (!r) begin
            model_clear();
            return;
        end
        ha.push_back(a);
        hl.push_back(l);
        e = ha.size() - 1;
        cur = pair_at(e);
        if (cur[14:7] != pair_at(e - 1)) begin end
        if (cur[14:7] != pair_at(e - 1) >> 7) m_n = 0;
        else if (m_n < TO) m_n++;
        // A pair is captured on the step its unbroken run reaches ST+1 samples.
        stable = 1'b1;
        for (int k = 1; k <= ST; k++) if (pair_at(e - k) != cur) stable = 1'b0;
        if (stable && pair_at(e - ST - 1) != cur && cur[14:7] != 8'hFF) begin
            if ($countones(~cur[14:7]) == 1) begin
                d = 0;
                for (int i = 0; i < 8; i++) if (!cur[7 + i]) d = i;
                v = lookup(cur[6:0]);
                if (v >= 0) begin
                    m_values[d] = 4'(v);
                    m_valid[d]  = 1'b1;
                    m_blank[d]  = (v == 15);
                end else begin
                    m_valid[d] = 1'b0;
                    m_blank[d] = 1'b0;
                    m_se       = 1'b1;
                end
                m_seen[d] = 1'b1;
                all = 0;
                for (int i = 0; i < 8; i++) all += m_seen[i];
                if (all == 8) begin
                    m_fd = 1'b1;
                    for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
                end
            end else begin
                m_ae = 1'b1;
            end
        end
    endtask

    task automatic compare();
        logic [31:0] ev;
        logic [7:0]  evd, ebl;
        logic        est;
        int          step;
        for (int d = 0; d < 8; d++) begin
            ev[d*4 +: 4] = m_values[d];
            evd[d] = m_valid[d];
            ebl[d] = m_blank[d];
        end
        est = (m_n == TO);
        step = ha.size() - 1;
        checks++;
        if (digit_values !== ev || digit_valid !== evd || digit_blank !== ebl ||
            frame_done !== m_fd || seg_error !== m_se || anode_error !== m_ae ||
            scan_stalled !== est) begin
            errors++;
            $display("FAIL outputs step %0d: actual/required values %h/%h valid %b/%b blank %b/%b fd %b/%b se %b/%b ae %b/%b stall %b/%b",
                     step, digit_values, ev, digit_valid, evd, digit_blank, ebl,
                     frame_done, m_fd, seg_error, m_se, anode_error, m_ae, scan_stalled, est);
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            last_fd_step = step;
        end
        if (seg_error === 1'b1) se_cnt++;
        if (anode_error === 1'b1) ae_cnt++;
        if (scan_stalled === 1'b1 && !prev_stall) stall_rise = step;
        if (scan_stalled === 1'b0 && prev_stall) stall_fall = step;
        prev_stall = (scan_stalled === 1'b1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare next fall.
    task automatic cycle(input logic [7:0] a, input logic [6:0] l, input logic r);
        reset = r;
        anode_activate = a;
        led_out = l;
        @(posedge clock);
        model_step(a, l, r);
        @(negedge clock);
        compare();
    endtask

    task automatic hold(input logic [7:0] a, input logic [6:0] l, input int n);
        repeat (n) cycle(a, l, 1'b1);
    endtask

    function automatic logic [7:0] sel(input int d);
        logic [7:0] a;
        a = 8'hFF;
        a[d] = 1'b0;
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, fd0, se0, ae0;
        logic [7:0] a;
        logic [6:0] p;
        int dw, r;
        model_clear();
        @(negedge clock);
        repeat (3) cycle(8'hFF, 7'h7F, 1'b0);
        chk("reset_values", digit_values, 32'h0);
        chk("reset_flags", {digit_valid, digit_blank, 4'h0, frame_done, seg_error, anode_error, scan_stalled}, 32'h0);

        // Full scan of 0..7.
        fd0 = fd_cnt;
        k = 0;
        for (int d = 0; d < 8; d++) begin
            if (d == 7) k = ha.size();
            hold(sel(d), PAT[d], 10);
        end
        chk("scan_values", digit_values, 32'h76543210);
        chk("scan_valid", {24'h0, digit_valid}, 32'hFF);
        chk("scan_blank", {24'h0, digit_blank}, 32'h0);
        chk("scan_frames", 32'(fd_cnt - fd0), 32'd1);
        chk("frame_latency", 32'(last_fd_step - k), 32'd6);

        // Segment toggling on digit 3 must not capture until it settles.
        for (int i = 0; i < 5; i++) hold(sel(3), (i % 2) ? PAT[1] : PAT[0], 2);
        k = ha.size();
        hold(sel(3), PAT[1], 6);
        chk("toggle_no_capture", {28'h0, digit_values[15:12]}, 32'h3);
        hold(sel(3), PAT[1], 1);
        chk("toggle_capture", {28'h0, digit_values[15:12]}, 32'h1);
        chk("toggle_step", 32'(ha.size() - 1 - k), 32'd6);

        // Illegal pattern on digit 5, then a legal 8.
        se0 = se_cnt;
        hold(sel(5), 7'b1111110, 10);
        chk("seg_err_pulses", 32'(se_cnt - se0), 32'd1);
        chk("seg_err_valid5", {31'h0, digit_valid[5]}, 32'h0);
        chk("seg_err_keep5", {28'h0, digit_values[23:20]}, 32'h5);
        hold(sel(5), PAT[8], 10);
        chk("recover_valid5", {31'h0, digit_valid[5]}, 32'h1);
        chk("recover_val5", {28'h0, digit_values[23:20]}, 32'h8);

        // Two anodes low.
        ae0 = ae_cnt;
        fd0 = fd_cnt;
        hold(8'b11100111, PAT[2], 10);
        chk("anode_err_pulses", 32'(ae_cnt - ae0), 32'd1);
        chk("anode_err_values", digit_values, 32'h76841210);
        chk("anode_err_noframe", 32'(fd_cnt - fd0), 32'd0);

        // Blank on digit 2.
        hold(sel(2), 7'h7F, 10);
        chk("blank_flag2", {31'h0, digit_blank[2]}, 32'h1);
        chk("blank_valid2", {31'h0, digit_valid[2]}, 32'h1);
        chk("blank_val2", {28'h0, digit_values[11:8]}, 32'hF);

        // Stall on a held anode, then release.
        k = ha.size();
        hold(8'hFE, PAT[4], 60);
        chk("stall_rise", 32'(stall_rise - k), 32'd52);
        chk("stall_level", {31'h0, scan_stalled}, 32'h1);
        k = ha.size();
        hold(8'hFD, PAT[4], 5);
        chk("stall_fall", 32'(stall_fall - k), 32'd2);
        chk("stall_clear", {31'h0, scan_stalled}, 32'h0);

        // Reset mid-frame, then one clean frame.
        for (int d = 0; d < 5; d++) hold(sel(d), PAT[9 - d], 8);
        repeat (3) cycle(sel(5), PAT[1], 1'b0);
        chk("midreset_values", digit_values, 32'h0);
        chk("midreset_flags", {digit_valid, digit_blank, 4'h0, frame_done, seg_error, anode_error, scan_stalled}, 32'h0);
        fd0 = fd_cnt;
        for (int d = 0; d < 8; d++) hold(sel(d), PAT[(d + 3) % 10], 10);
        chk("post_reset_frames", 32'(fd_cnt - fd0), 32'd1);
        chk("post_reset_values", digit_values, 32'h09876543);
        chk("post_reset_valid", {24'h0, digit_valid}, 32'hFF);

        // Random scan traffic.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8) a = sel($urandom_range(0, 7));
            else if (r == 8) a = 8'hFF;
            else a = 8'($urandom);
            if ($urandom_range(0, 4) != 0) begin
                r = $urandom_range(0, 10);
                p = (r == 10) ? 7'h7F : PAT[r];
            end else begin
                p = 7'($urandom);
            end
            dw = $urandom_range(1, 12);
            if ($urandom_range(0, 99) == 0) dw = 55;
            if ($urandom_range(0, 149) == 0) begin
                repeat (2) cycle(a, p, 1'b0);
            end else if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < dw; i++) hold(a, (i % 2) ? p : ~p, 1);
            end else begin
                hold(a, p, dw);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
